// File: rtl/riscv_pipe_pkg.sv
// Shared IF->ID pipeline types: bubble encoding, payload struct and stage occupancy states.
package riscv_pipe_pkg;

    localparam int          FD_XLEN   = 32;
    localparam int          FD_ILEN   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FD_ILEN-1:0] instr;
        logic [FD_XLEN-1:0] pc;
        logic [FD_XLEN-1:0] pcplus4;
    } fd_payload_t;

    // Encoded as {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        FD_EMPTY = 2'b00,
        FD_BUSY  = 2'b10,
        FD_FULL  = 2'b11
    } fd_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Enable-loaded payload register with a configurable reset value.
module pipe_payload_reg
    import riscv_pipe_pkg::*;
#(
    parameter type T       = fd_payload_t,
    parameter T    RST_VAL = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  T     i_d,
    output T     o_q
);

    T r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_q <= RST_VAL;
        else if (i_en) r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// IF->ID stage: valid/ready handshake, main + skid payload registers, flush to NOP bubble.
// Optional perf counters (stall/flush) are built when FD_PERF_CNT_EN is defined.
module fetch_decode_stage #(
    parameter int             XLEN      = 32,
    parameter int             ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(riscv_pipe_pkg::NOP_INSTR)
`ifdef FD_PERF_CNT_EN
    ,
    parameter int             CNT_W     = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            valid_f_i,
    output logic            ready_f_o,
    input  logic [ILEN-1:0] instr_f_i,
    input  logic [XLEN-1:0] pc_f_i,
    input  logic [XLEN-1:0] pcplus4_f_i,
    output logic            valid_d_o,
    input  logic            ready_d_i,
    output logic [ILEN-1:0] instr_d_o,
    output logic [XLEN-1:0] pc_d_o,
    output logic [XLEN-1:0] pcplus4_d_o
`ifdef FD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);
    import riscv_pipe_pkg::*;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
    } pl_t;

    localparam pl_t MAIN_RST = '{instr: NOP_INSTR, pc: '0, pcplus4: '0};

    fd_state_e r_state, w_state_nxt;
    logic      r_ready_f;
    logic      w_accept_f, w_take_d;
    logic      w_load_main, w_load_skid, w_main_from_skid;
    pl_t       w_in, w_main_d, w_main_q, w_skid_q;

    assign w_in       = '{instr: instr_f_i, pc: pc_f_i, pcplus4: pcplus4_f_i};
    assign valid_d_o  = r_state[1];
    assign w_accept_f = valid_f_i & r_ready_f;
    assign w_take_d   = valid_d_o & ready_d_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            FD_EMPTY: begin
                if (w_accept_f) begin
                    w_load_main = 1'b1;
                    w_state_nxt = FD_BUSY;
                end
            end
            FD_BUSY: begin
                if (w_accept_f && w_take_d) begin
                    w_load_main = 1'b1;
                end else if (w_accept_f) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = FD_FULL;
                end else if (w_take_d) begin
                    w_state_nxt = FD_EMPTY;
                end
            end
            FD_FULL: begin
                if (w_take_d) begin
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = FD_BUSY;
                end
            end
            default: w_state_nxt = FD_EMPTY;
        endcase
        // Flush overrides everything: drop all beats, show a bubble, keep the PCs.
        if (flush_i) begin
            w_state_nxt = FD_EMPTY;
            w_load_main = 1'b1;
            w_load_skid = 1'b0;
        end
    end

    always_comb begin
        if (flush_i)               w_main_d = '{instr: NOP_INSTR, pc: w_main_q.pc, pcplus4: w_main_q.pcplus4};
        else if (w_main_from_skid) w_main_d = w_skid_q;
        else                       w_main_d = w_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FD_EMPTY;
            r_ready_f <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_ready_f <= (w_state_nxt != FD_FULL);
        end
    end

    pipe_payload_reg #(.T(pl_t), .RST_VAL(MAIN_RST)) u_main (
        .clk (clk),
        .rst (rst),
        .i_en(w_load_main),
        .i_d (w_main_d),
        .o_q (w_main_q)
    );

    pipe_payload_reg #(.T(pl_t), .RST_VAL('0)) u_skid (
        .clk (clk),
        .rst (rst),
        .i_en(w_load_skid),
        .i_d (w_in),
        .o_q (w_skid_q)
    );

    assign ready_f_o   = r_ready_f;
    assign instr_d_o   = w_main_q.instr;
    assign pc_d_o      = w_main_q.pc;
    assign pcplus4_d_o = w_main_q.pcplus4;

`ifdef FD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (valid_d_o && !ready_d_i && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_i && r_flush_cnt != '1)                 r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: directed scenarios plus random traffic vs a queue model.
module tb_fetch_decode_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FD_PERF_CNT_EN
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, valid_f_i, ready_f_o, valid_d_o, ready_d_i;
    logic [31:0] instr_f_i, pc_f_i, pcplus4_f_i, instr_d_o, pc_d_o, pcplus4_d_o;
`ifdef FD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .valid_f_i  (valid_f_i),
        .ready_f_o  (ready_f_o),
        .instr_f_i  (instr_f_i),
        .pc_f_i     (pc_f_i),
        .pcplus4_f_i(pcplus4_f_i),
        .valid_d_o  (valid_d_o),
        .ready_d_i  (ready_d_i),
        .instr_d_o  (instr_d_o),
        .pc_d_o     (pc_d_o),
        .pcplus4_d_o(pcplus4_d_o)
`ifdef FD_PERF_CNT_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] i;
        logic [31:0] p;
        logic [31:0] p4;
    } beat_t;

    // Model: the stage is a FIFO of at most two beats; decode sees the oldest.
    beat_t q[$];
    beat_t disp;
    int    stall_m, flush_m;
    int    errs = 0;
    int    checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        disp    = '{i: NOP, p: 32'h0, p4: 32'h0};
        stall_m = 0;
        flush_m = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(valid_d_o), 64'(q.size() > 0));
        chk({tag, ".ready"}, 64'(ready_f_o), 64'(q.size() < 2));
        chk({tag, ".instr"}, 64'(instr_d_o), 64'(disp.i));
        chk({tag, ".pc"},    64'(pc_d_o),    64'(disp.p));
        chk({tag, ".pc4"},   64'(pcplus4_d_o), 64'(disp.p4));
`ifdef FD_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(stall_m));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(flush_m));
`endif
    endtask

    // One clock: drive inputs, predict, advance past the edge, compare.
    task automatic step(input string tag, input logic fl, input logic vf, input logic rd,
                        input logic [31:0] ins, input logic [31:0] pc);
        bit    acc, tk;
        beat_t b;
        flush_i     = fl;
        valid_f_i   = vf;
        ready_d_i   = rd;
        instr_f_i   = ins;
        pc_f_i      = pc;
        pcplus4_f_i = pc + 32'd4;
        b   = '{i: ins, p: pc, p4: pc + 32'd4};
        acc = vf && (q.size() < 2);
        tk  = (q.size() > 0) && rd;
`ifdef FD_PERF_CNT_EN
        if (q.size() > 0 && !rd && stall_m < CMAX) stall_m++;
        if (fl && flush_m < CMAX) flush_m++;
`endif
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            disp.i = NOP;
        end else begin
            if (tk)  void'(q.pop_front());
            if (acc) q.push_back(b);
            if (q.size() > 0) disp = q[0];
        end
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 0; valid_f_i = 0; ready_d_i = 0;
        instr_f_i = 0; pc_f_i = 0; pcplus4_f_i = 0;
        model_reset();
        #2;
        check_all("reset");
        #10;
        rst = 1'b0;

        // Stream at full rate
        step("stream0", 0, 1, 1, 32'h0000_0093, 32'h0);
        chk("stream0.pc_abs", 64'(pc_d_o), 64'h0);
        step("stream1", 0, 1, 1, 32'h0010_0113, 32'h4);
        chk("stream1.pc_abs", 64'(pc_d_o), 64'h4);
        step("stream2", 0, 1, 1, 32'h0020_0193, 32'h8);
        chk("stream2.pc_abs", 64'(pc_d_o), 64'h8);
        step("drain0", 0, 0, 1, 32'h0, 32'h0);

        // Back-pressure: fill skid, third beat waits at fetch, then release
        step("bp0", 0, 1, 0, 32'hA000_0001, 32'h100);
        step("bp1", 0, 1, 0, 32'hA000_0002, 32'h104);
        chk("bp1.ready_low", 64'(ready_f_o), 64'h0);
        step("bp2", 0, 1, 0, 32'hA000_0003, 32'h108);
        step("bp3", 0, 1, 1, 32'hA000_0003, 32'h108);
        chk("bp3.second_beat", 64'(pc_d_o), 64'h104);
        step("bp4", 0, 1, 1, 32'hA000_0003, 32'h108);
        step("bp5", 0, 0, 1, 32'h0, 32'h0);
        step("bp6", 0, 0, 1, 32'h0, 32'h0);

        // Flush while FULL
        step("ff0", 0, 1, 0, 32'hB000_0001, 32'h200);
        step("ff1", 0, 1, 0, 32'hB000_0002, 32'h204);
        step("ff2", 1, 0, 0, 32'h0, 32'h0);
        chk("ff2.instr_nop", 64'(instr_d_o), 64'h13);

        // Flush coincident with a fetch beat
        step("fv0", 1, 1, 1, 32'h0050_0093, 32'h300);
        chk("fv0.dropped", 64'(valid_d_o), 64'h0);

        // Async reset between edges
        step("ar0", 0, 1, 0, 32'hC000_0001, 32'h400);
        step("ar1", 0, 1, 0, 32'hC000_0002, 32'h404);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b0;

`ifdef FD_PERF_CNT_EN
        step("pc0", 0, 1, 0, 32'hD000_0001, 32'h500);
        for (int k = 0; k < 5; k++) step("pc_stall", 0, 0, 0, 32'h0, 32'h0);
        step("pc_f0", 1, 0, 1, 32'h0, 32'h0);
        step("pc_f1", 1, 0, 1, 32'h0, 32'h0);
        chk("perf.stall5", 64'(stall_cnt_o), 64'd5);
        chk("perf.flush2", 64'(flush_cnt_o), 64'd2);
`endif

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step("rand",
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 $urandom, $urandom & 32'hFFFF_FFFC);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
